// File: rtl/tdm_demux8_if.sv
// Signal bundle between the TDM slot stream source and the tdm_demux8 receiver.
interface tdm_demux8_if;
  logic       din;
  logic       en;
  logic       sync;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] sel;
  logic       locked;
  logic       frame_err;
  logic       par_err;

  modport master (
    output din, en, sync,
    input  y, y_valid, sel, locked, frame_err, par_err
  );

  modport slave (
    input  din, en, sync,
    output y, y_valid, sel, locked, frame_err, par_err
  );
endinterface

// File: rtl/tdm_demux8.sv
// Receive-side 1-to-8 TDM demultiplexer with sync-based frame alignment.
// Define DEMUX8_PARITY_EN for 9-slot frames carrying even parity in slot 8.
module tdm_demux8 (
  input  logic          clk,
  input  logic          rst_n,
  tdm_demux8_if.slave   bus
);

`ifdef DEMUX8_PARITY_EN
  localparam int SEL_W = 4;
  localparam int SH_W  = 8;
  localparam logic [SEL_W-1:0] LAST_SLOT = 4'd8;
`else
  localparam int SEL_W = 3;
  localparam int SH_W  = 7;
  localparam logic [SEL_W-1:0] LAST_SLOT = 3'd7;
`endif

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [SEL_W-1:0] r_sel, w_sel_next;
  logic [SH_W-1:0]  r_sh, w_sh_next;
  logic [7:0]       r_y, w_y_next;
  logic             r_y_valid, w_y_valid_next;
  logic             r_frame_err, w_frame_err_next;
`ifdef DEMUX8_PARITY_EN
  logic             r_par_err, w_par_err_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_sel       <= '0;
      r_sh        <= '0;
      r_y         <= 8'h00;
      r_y_valid   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef DEMUX8_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_sh        <= w_sh_next;
      r_y         <= w_y_next;
      r_y_valid   <= w_y_valid_next;
      r_frame_err <= w_frame_err_next;
`ifdef DEMUX8_PARITY_EN
      r_par_err   <= w_par_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_sh_next        = r_sh;
    w_y_next         = r_y;
    w_y_valid_next   = 1'b0;
    w_frame_err_next = 1'b0;
`ifdef DEMUX8_PARITY_EN
    w_par_err_next   = 1'b0;
`endif
    if (bus.en) begin
      unique case (r_state)
        HUNT: begin
          if (bus.sync) begin
            w_sh_next[0] = bus.din;
            w_sel_next   = 1;
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (r_sel == '0) begin
            if (bus.sync) begin
              w_sh_next[0] = bus.din;
              w_sel_next   = 1;
            end else begin
              w_frame_err_next = 1'b1;
              w_state_next     = HUNT;
            end
          end else if (bus.sync) begin
            // Early sync: drop the partial frame and realign on this bit.
            w_frame_err_next = 1'b1;
            w_sh_next[0]     = bus.din;
            w_sel_next       = 1;
          end else if (r_sel == LAST_SLOT) begin
            w_sel_next = '0;
`ifdef DEMUX8_PARITY_EN
            if ((^{r_sh, bus.din}) == 1'b0) begin
              w_y_next       = r_sh;
              w_y_valid_next = 1'b1;
            end else begin
              w_par_err_next = 1'b1;
            end
`else
            w_y_next       = {bus.din, r_sh};
            w_y_valid_next = 1'b1;
`endif
          end else begin
            w_sh_next[r_sel[2:0]] = bus.din;
            w_sel_next            = r_sel + 1'b1;
          end
        end
        default: w_state_next = HUNT;
      endcase
    end
  end

  assign bus.y         = r_y;
  assign bus.y_valid   = r_y_valid;
  assign bus.sel       = r_sel[2:0];
  assign bus.locked    = (r_state == RUN);
  assign bus.frame_err = r_frame_err;
`ifdef DEMUX8_PARITY_EN
  assign bus.par_err   = r_par_err;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux8.sv
// Table-driven bench for tdm_demux8: per-cycle vectors plus a mid-frame reset sequence.
module tb_tdm_demux8;
  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  tdm_demux8_if tif ();

  tdm_demux8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sync;
    logic       din;
    logic [7:0] y;
    logic       yv;
    logic       lk;
    logic       fe;
    logic [2:0] sel;
    logic       pe;
  } vec_t;

  vec_t vt[80];
  int   nv = 0;

  task automatic add(input logic e, input logic s, input logic d, input logic [7:0] y,
                     input logic yv, input logic lk, input logic fe, input int sel,
                     input logic pe);
    vt[nv].en   = e;
    vt[nv].sync = s;
    vt[nv].din  = d;
    vt[nv].y    = y;
    vt[nv].yv   = yv;
    vt[nv].lk   = lk;
    vt[nv].fe   = fe;
    vt[nv].sel  = sel[2:0];
    vt[nv].pe   = pe;
    nv++;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] y, input logic yv, input logic lk,
                         input logic fe, input logic [2:0] sel, input logic pe);
    chk({tag, ".y"},         tif.y,                 y);
    chk({tag, ".y_valid"},   {7'd0, tif.y_valid},   {7'd0, yv});
    chk({tag, ".locked"},    {7'd0, tif.locked},    {7'd0, lk});
    chk({tag, ".frame_err"}, {7'd0, tif.frame_err}, {7'd0, fe});
    chk({tag, ".sel"},       {5'd0, tif.sel},       {5'd0, sel});
    chk({tag, ".par_err"},   {7'd0, tif.par_err},   {7'd0, pe});
  endtask

  task automatic step(input logic e, input logic s, input logic d);
    tif.en   = e;
    tif.sync = s;
    tif.din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    rst_n    = 1'b0;
    tif.en   = 1'b0;
    tif.sync = 1'b0;
    tif.din  = 1'b0;

`ifdef DEMUX8_PARITY_EN
    add(1, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    v = 8'hA5;
    add(1, 1, v[0], 8'h00, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, v[k], 8'h00, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'h00, 0, 1, 0, 0, 0);
    add(1, 0, 0,    8'hA5, 1, 1, 0, 0, 0);
    v = 8'h01;
    add(1, 1, v[0], 8'hA5, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, v[k], 8'hA5, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'hA5, 0, 1, 0, 0, 0);
    add(1, 0, 0,    8'hA5, 0, 1, 0, 0, 1);
`else
    add(1, 0, 1, 8'h00, 0, 0, 0, 0, 0);
    v = 8'hA5;
    add(1, 1, v[0], 8'h00, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, v[k], 8'h00, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'hA5, 1, 1, 0, 0, 0);
    // 0x3C with an en gap after slot 1
    v = 8'h3C;
    add(1, 1, v[0], 8'hA5, 0, 1, 0, 1, 0);
    add(1, 0, v[1], 8'hA5, 0, 1, 0, 2, 0);
    add(0, 1, 1,    8'hA5, 0, 1, 0, 2, 0);
    for (int k = 2; k <= 6; k++) add(1, 0, v[k], 8'hA5, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'h3C, 1, 1, 0, 0, 0);
    add(0, 0, 1,    8'h3C, 0, 1, 0, 0, 0);
    // 0xFF with a two-cycle gap after slot 3
    v = 8'hFF;
    add(1, 1, v[0], 8'h3C, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 3; k++) add(1, 0, v[k], 8'h3C, 0, 1, 0, k + 1, 0);
    add(0, 0, 0, 8'h3C, 0, 1, 0, 4, 0);
    add(0, 0, 0, 8'h3C, 0, 1, 0, 4, 0);
    for (int k = 4; k <= 6; k++) add(1, 0, v[k], 8'h3C, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'hFF, 1, 1, 0, 0, 0);
    // early sync at slot 4 restarts as frame 0x81
    add(1, 1, 0, 8'hFF, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 3; k++) add(1, 0, 0, 8'hFF, 0, 1, 0, k + 1, 0);
    v = 8'h81;
    add(1, 1, v[0], 8'hFF, 0, 1, 1, 1, 0);
    for (int k = 1; k <= 6; k++) add(1, 0, v[k], 8'hFF, 0, 1, 0, k + 1, 0);
    add(1, 0, v[7], 8'h81, 1, 1, 0, 0, 0);
    // missing sync at slot 0 drops lock
    add(1, 0, 1, 8'h81, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 1, 8'h81, 0, 0, 0, 0, 0);
    add(0, 1, 1, 8'h81, 0, 0, 0, 0, 0);
    add(1, 1, 0, 8'h81, 0, 1, 0, 1, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 0, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      step(vt[i].en, vt[i].sync, vt[i].din);
      $display("vec %0d en=%b sync=%b din=%b -> y=%h yv=%b sel=%0d lk=%b fe=%b pe=%b",
               i, vt[i].en, vt[i].sync, vt[i].din, tif.y, tif.y_valid, tif.sel,
               tif.locked, tif.frame_err, tif.par_err);
      chk_all($sformatf("vec%0d", i), vt[i].y, vt[i].yv, vt[i].lk, vt[i].fe, vt[i].sel, vt[i].pe);
    end

    // Mid-frame asynchronous reset, then recovery only after a new sync
    step(1, 0, 0);
    step(1, 0, 1);
    chk("midframe.sel", {5'd0, tif.sel}, 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-frame -> y=%h sel=%0d lk=%b", tif.y, tif.sel, tif.locked);
    chk_all("async_rst", 8'h00, 0, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 1);
      $display("post-reset bit %0d -> yv=%b sel=%0d lk=%b", k, tif.y_valid, tif.sel, tif.locked);
      chk_all($sformatf("postrst%0d", k), 8'h00, 0, 0, 0, 3'd0, 0);
    end
    step(1, 1, 1);
    $display("post-reset sync -> sel=%0d lk=%b", tif.sel, tif.locked);
    chk_all("resync", 8'h00, 0, 1, 0, 3'd1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
